// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin burst arbiter.
//   state_e        : arbiter FSM states (IDLE = no owner, BUSY = grant held)
//   NUM_REQ_DEF    : default number of requesters
//   owner_t        : binary owner index type
//   HOLD_W         : width of the optional hold counter
//   onehot_to_idx  : converts a one-hot grant vector to its binary index
package rr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int NUM_REQ_DEF = 4;
   localparam int HOLD_W      = 8;

   typedef logic [1:0] owner_t;

   function automatic owner_t onehot_to_idx(input logic [3:0] oh);
      owner_t idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) idx = owner_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   req     in  : request vector, bit i = requester i
//   ptr     in  : index holding the highest priority this cycle
//   winner  out : one-hot winner (all zero when no request)
//   any_req out : at least one request is present
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               any_req
);

   // Walk the requesters in the order ptr, ptr+1, ... (mod 4); the first
   // asserted one wins. The 2-bit index wraps naturally.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one of four requesters and holds the
// grant until the shared resource signals done, the owner drops its request,
// or (optionally) a hold limit expires. On release the next owner is granted
// in the same cycle boundary with no idle bubble, the releasing owner being
// last in line.
// Optional feature: define RR_BURST_ARBITER_TIMEOUT_EN to build the hold
// counter and the forced-revocation timeout pulse.
// Ports:
//   clk         in  : clock, all state on posedge
//   rst_n       in  : synchronous active-low reset
//   req         in  : request levels, bit i = requester i
//   done        in  : one-cycle completion pulse for the current owner
//   grant       out : registered one-hot grant, zero when idle
//   grant_valid out : registered, equals |grant
//   owner_id    out : registered binary index of the owner, 0 when idle
//   timeout     out : registered one-cycle pulse on forced revocation
module rr_burst_arbiter
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [1:0]         owner_id,
   output logic               timeout
);

   state_e             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         owner_q, owner_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               valid_q;
   logic [1:0]         pick_ptr;
   logic [NUM_REQ-1:0] winner;
   logic               any_req;
   logic               release_ev;
   logic               new_grant;
   logic               expire;

   // At a release the picker already sees the rotated pointer, so the
   // releasing owner sits at lowest priority and the next grant is immediate.
   assign pick_ptr = (state_q == BUSY) ? owner_q + 2'd1 : ptr_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req     (req),
      .ptr     (pick_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign release_ev = (state_q == BUSY) && (done || !req[owner_q] || expire);
   assign new_grant  = any_req && ((state_q == IDLE) || release_ev);

`ifdef RR_BURST_ARBITER_TIMEOUT_EN
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;

   // hold_q counts completed BUSY cycles of the current owner; the cycle in
   // which it reaches MAX_HOLD-1 is the owner's last.
   assign expire = (state_q == BUSY) && (hold_q == HOLD_LAST);

   always_comb begin
      hold_d = '0;
      if (new_grant) begin
         hold_d = '0;
      end else if (state_q == BUSY) begin
         hold_d = hold_q + 1'b1;
      end
      // Pulse only when the limit alone caused the release.
      timeout_d = expire && !done && req[owner_q];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = BUSY;
         BUSY:    if (release_ev && !any_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (release_ev) begin
         ptr_d = owner_q + 2'd1;
      end
      if (new_grant) begin
         grant_d = winner;
         owner_d = onehot_to_idx(winner);
      end else if (release_ev) begin
         grant_d = '0;
         owner_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q <= '0;
         valid_q <= 1'b0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         grant_q <= grant_d;
         valid_q <= |grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign owner_id    = owner_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;
   import rr_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] owner_id;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   rr_burst_arbiter #(
      .NUM_REQ  (4),
      .MAX_HOLD (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .owner_id    (owner_id),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then stable and inputs may be changed.
   // Every cycle also checks the one-hot / valid / owner consistency.
   task automatic tick();
      logic [1:0] exp_id;
      @(posedge clk);
      #1;
      exp_id = 2'd0;
      for (int i = 0; i < 4; i++) if (grant[i]) exp_id = 2'(i);
      total++;
      if (!$onehot0(grant) || grant_valid !== (|grant) || owner_id !== exp_id) begin
         bad++;
         $display("FAIL consistency grant=%b valid=%b owner=%0d want onehot0, valid=%b owner=%0d",
                  grant, grant_valid, owner_id, |grant, exp_id);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || owner_id !== 2'd0 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got grant=%b valid=%b owner=%0d to=%b want 0000/0/0/0",
                  grant, grant_valid, owner_id, timeout);
      end
      total++;
      if (dut.ptr_q !== 2'd0 || dut.state_q !== IDLE) begin
         bad++;
         $display("FAIL reset_state got ptr=%0d state=%0d want ptr=0 state=IDLE", dut.ptr_q, dut.state_q);
      end
   endtask

   task automatic test_basic();
      do_reset();
      req = 4'b0101;
      tick();
      total++;
      if (grant !== 4'b0001 || owner_id !== 2'd0) begin
         bad++;
         $display("FAIL basic_first got grant=%b owner=%0d want 0001/0", grant, owner_id);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (grant !== 4'b0100 || owner_id !== 2'd2 || dut.ptr_q !== 2'd1) begin
         bad++;
         $display("FAIL basic_second got grant=%b owner=%0d ptr=%0d want 0100/2/1", grant, owner_id, dut.ptr_q);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (grant !== 4'b0001 || dut.ptr_q !== 2'd3) begin
         bad++;
         $display("FAIL basic_third got grant=%b ptr=%0d want 0001/3", grant, dut.ptr_q);
      end
      req = 4'b0000;
      tick();
      total++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || dut.state_q !== IDLE) begin
         bad++;
         $display("FAIL basic_idle got grant=%b valid=%b state=%0d want 0000/0/IDLE", grant, grant_valid, dut.state_q);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      do_reset();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 2; c++) begin
            total++;
            if (grant !== seq[i]) begin
               bad++;
               $display("FAIL rotation_hold%0d got grant=%b want %b", i, grant, seq[i]);
            end
            if (c == 1) done = 1'b1;
            tick();
         end
         done = 1'b0;
         total++;
         if (grant !== seq[i+1]) begin
            bad++;
            $display("FAIL rotation_next%0d got grant=%b want %b", i, grant, seq[i+1]);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b1000;
      tick();
      total++;
      if (grant !== 4'b1000 || owner_id !== 2'd3) begin
         bad++;
         $display("FAIL wrap_first got grant=%b owner=%0d want 1000/3", grant, owner_id);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (grant !== 4'b1000 || dut.ptr_q !== 2'd0) begin
         bad++;
         $display("FAIL wrap_regrant got grant=%b ptr=%0d want 1000/0", grant, dut.ptr_q);
      end
      req  = 4'b0000;
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || owner_id !== 2'd0 || dut.state_q !== IDLE) begin
         bad++;
         $display("FAIL wrap_idle got grant=%b valid=%b owner=%0d state=%0d want 0000/0/0/IDLE",
                  grant, grant_valid, owner_id, dut.state_q);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (grant !== 4'b0000 || dut.ptr_q !== 2'd0 || dut.state_q !== IDLE) begin
         bad++;
         $display("FAIL idle_done got grant=%b ptr=%0d state=%0d want 0000/0/IDLE", grant, dut.ptr_q, dut.state_q);
      end
   endtask

   task automatic test_abort();
      do_reset();
      req = 4'b0010;
      tick();
      total++;
      if (grant !== 4'b0010) begin
         bad++;
         $display("FAIL abort_first got grant=%b want 0010", grant);
      end
      req = 4'b0111;
      tick();
      total++;
      if (grant !== 4'b0010) begin
         bad++;
         $display("FAIL no_preempt got grant=%b want 0010", grant);
      end
      req = 4'b0100;
      tick();
      total++;
      if (grant !== 4'b0100 || timeout !== 1'b0 || dut.ptr_q !== 2'd2) begin
         bad++;
         $display("FAIL abort_next got grant=%b to=%b ptr=%0d want 0100/0/2", grant, timeout, dut.ptr_q);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0011;
      tick();
      total++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL hold_first got grant=%b to=%b want 0001/0", grant, timeout);
      end
`ifdef RR_BURST_ARBITER_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (grant !== 4'b0001 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL hold_cycle%0d got grant=%b to=%b want 0001/0", i, grant, timeout);
         end
      end
      tick();
      total++;
      if (grant !== 4'b0010 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_switch got grant=%b to=%b want 0010/1", grant, timeout);
      end
      tick();
      total++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL timeout_pulse got grant=%b to=%b want 0010/0", grant, timeout);
      end
`else
      begin
         int errs;
         errs = 0;
         for (int i = 0; i < 110; i++) begin
            tick();
            if (grant !== 4'b0001 || timeout !== 1'b0) errs++;
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL hold_forever got %0d cycles off 0001/to=0 want 0 (last grant=%b to=%b)",
                     errs, grant, timeout);
         end
      end
`endif
   endtask

   task automatic test_reset_busy();
      do_reset();
      req = 4'b1111;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (grant !== 4'b0010 || dut.ptr_q !== 2'd1) begin
         bad++;
         $display("FAIL rb_setup got grant=%b ptr=%0d want 0010/1", grant, dut.ptr_q);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if (grant !== 4'b0000 || timeout !== 1'b0 || dut.ptr_q !== 2'd0) begin
         bad++;
         $display("FAIL rb_drop got grant=%b to=%b ptr=%0d want 0000/0/0", grant, timeout, dut.ptr_q);
      end
      tick();
      total++;
      if (grant !== 4'b0001 || owner_id !== 2'd0) begin
         bad++;
         $display("FAIL rb_regrant got grant=%b owner=%0d want 0001/0", grant, owner_id);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      test_reset();
      test_basic();
      test_rotation();
      test_wrap();
      test_abort();
      test_timeout();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
